// File: rtl/display_scanner.sv
// display_scanner: time-multiplexes six 7-segment patterns onto one bus.
// Frame-coherent snapshots, inter-digit blanking, per-digit blink and colon.
module display_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int BLINK_FRAMES   = 64,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] sec_units_display,
  input  logic [6:0] sec_tens_display,
  input  logic [6:0] min_units_display,
  input  logic [6:0] min_tens_display,
  input  logic [6:0] hour_units_display,
  input  logic [6:0] hour_tens_display,
  input  logic [5:0] blink_mask,
  input  logic       colon_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [31:0]   BLANK_LEN  = 32'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF    = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic          DP_OFF     = ACTIVE_LOW_SEG;

  logic [2:0]    r_slot;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [6:0]    r_snap [0:5];
  logic [5:0]    r_mask;
  logic          r_colon;

  logic          w_cap;
  logic          w_div_last;
  logic          w_frame_last;
  logic          w_blank;
  logic          w_dark;
  logic          w_mask_bit;
  logic          w_dp_slot;
  logic [6:0]    w_pat;
  logic [5:0]    w_an_on;
  logic [31:0]   w_div32;

  // Counters describe the slot position the next output clock will show.
  assign w_cap        = (r_slot == 3'd0) && (r_div == '0);
  assign w_div_last   = (r_div == DIV_LAST);
  assign w_frame_last = w_div_last && (r_slot == 3'd5);
  assign w_div32      = {{(32-DW){1'b0}}, r_div};
  assign w_blank      = (w_div32 < BLANK_LEN);
  assign w_dp_slot    = (r_slot == 3'd2) || (r_slot == 3'd4);
  assign w_an_on      = ~(6'd1 << r_slot);

  // Capture only ever happens in slot 0, so bypass the snapshot there.
  always_comb begin
    w_pat      = 7'h00;
    w_mask_bit = 1'b0;
    unique case (r_slot)
      3'd0: begin
        w_pat      = w_cap ? sec_units_display : r_snap[0];
        w_mask_bit = w_cap ? blink_mask[0] : r_mask[0];
      end
      3'd1: begin
        w_pat      = r_snap[1];
        w_mask_bit = r_mask[1];
      end
      3'd2: begin
        w_pat      = r_snap[2];
        w_mask_bit = r_mask[2];
      end
      3'd3: begin
        w_pat      = r_snap[3];
        w_mask_bit = r_mask[3];
      end
      3'd4: begin
        w_pat      = r_snap[4];
        w_mask_bit = r_mask[4];
      end
      3'd5: begin
        w_pat      = r_snap[5];
        w_mask_bit = r_mask[5];
      end
      default: begin
        w_pat      = 7'h00;
        w_mask_bit = 1'b0;
      end
    endcase
  end

  assign w_dark = w_blank || (r_blink_phase && w_mask_bit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_slot        <= 3'd0;
      r_div         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      for (int i = 0; i < 6; i++) r_snap[i] <= 7'h00;
      r_mask        <= 6'h00;
      r_colon       <= 1'b0;
      an            <= 6'h3F;
      seg           <= SEG_OFF;
      dp            <= DP_OFF;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= w_cap;
      if (w_cap) begin
        r_snap[0] <= sec_units_display;
        r_snap[1] <= sec_tens_display;
        r_snap[2] <= min_units_display;
        r_snap[3] <= min_tens_display;
        r_snap[4] <= hour_units_display;
        r_snap[5] <= hour_tens_display;
        r_mask    <= blink_mask;
        r_colon   <= colon_en;
      end
      if (w_div_last) begin
        r_div  <= '0;
        r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      // Phase flips between frames so a frame is never half blinked.
      if (w_frame_last) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
      an  <= w_dark ? 6'h3F : w_an_on;
      seg <= w_dark ? SEG_OFF : (ACTIVE_LOW_SEG ? ~w_pat : w_pat);
      dp  <= (!w_dark && r_colon && w_dp_slot) ? ~DP_OFF : DP_OFF;
    end
  end

endmodule
